gpio_cfg_serial_loader: RTL and testbench
=========================================

Name: gpio_cfg_serial_loader

Overview:
- Core-side transmitter that programs the per-pad GPIO configuration (dm, oeb, inp_dis, analog/vtrip/slow/holdover bits) held in the housekeeping register file.
- Shifts one configuration word per pad over a serial daisy chain, then pulses a load strobe.
- The chain registers sit beside the GPIO pad array and drive its per-pad control inputs.
- Sits in housekeeping, between the config register file and the chain entry point.

Parameters:
- NUM_PADS, 38, number of pads on the chain (pad 0 is nearest the loader).
- CFG_BITS, 13, configuration bits per pad.
- CLK_DIV, 2, core cycles per serial_clock half-period; legal range is 1 or more.
- LOAD_CYCLES, 2, core cycles serial_load is held high.

Ports:
- wb_clk_i, input, 1: core clock; the only clock.
- wb_rst_i, input, 1: synchronous, active-high reset.
- start, input, 1: one-cycle request to reload the whole chain.
- cfg_addr, output, $clog2(NUM_PADS): pad index being read from the register file.
- cfg_rdata, input, CFG_BITS: config word for cfg_addr; combinational, valid the same cycle.
- serial_clock, output, 1: chain shift clock; chain samples on its rising edge.
- serial_data_out, output, 1: chain data.
- serial_load, output, 1: transfer strobe from chain shift registers to pad control latches.
- busy, output, 1: transfer in progress.
- done, output, 1: one-cycle pulse when a transfer completes.

Behaviour:
- Clock and reset: one clock, wb_clk_i; reset wb_rst_i is synchronous and active-high.
- Reset values: state=IDLE; serial_clock=0, serial_data_out=0, serial_load=0, busy=0, done=0; cfg_addr=NUM_PADS-1.
- Send order: pads are sent highest index first, NUM_PADS-1 down to 0. Within a word, bits go MSB first, CFG_BITS-1 down to 0. After a full transfer, pad k holds cfg word k.
- IDLE: a start sampled high moves to FETCH next cycle. busy=0.
- FETCH (1 cycle): cfg_addr = pad counter; cfg_rdata is captured into the shift register; bit counter = CFG_BITS-1. Go to SHIFT_LO.
- SHIFT_LO (CLK_DIV cycles): serial_clock=0; serial_data_out = shift register MSB, held stable for the whole phase. Go to SHIFT_HI.
- SHIFT_HI (CLK_DIV cycles): serial_clock=1; serial_data_out unchanged. On exit:
  - if bits remain, shift left and go to SHIFT_LO;
  - else if pad counter > 0, decrement it and go to FETCH;
  - else go to LOAD.
- LOAD (LOAD_CYCLES cycles): serial_clock=0, serial_load=1. On exit go to DONE.
- DONE (1 cycle): done=1, busy=0, serial_load=0. Return to IDLE; a start present in this cycle is ignored.
- busy=1 in FETCH, SHIFT_LO, SHIFT_HI and LOAD.
- Latency: start at cycle 0 leads to done in cycle 1 + NUM_PADS*(1 + 2*CLK_DIV*CFG_BITS) + LOAD_CYCLES.
- Start while busy: ignored; no queuing.
- Reset mid-transfer: all outputs return to reset values on the next edge. serial_load must never pulse on an aborted transfer. The chain contents are then undefined until the next full transfer.
- cfg_rdata is sampled only in FETCH; changes outside FETCH have no effect on the transfer in progress.
- Counters: the pad counter wraps nowhere; it stops at 0. The divider counter width is $clog2(max(CLK_DIV, LOAD_CYCLES)) + 1.
- Outputs are registered; no glitches on serial_clock or serial_load.

Decomposition:
- Package gpio_cfg_pkg holds:
  - state enum: IDLE, FETCH, SHIFT_LO, SHIFT_HI, LOAD, DONE;
  - default CFG_BITS;
  - dm/oeb/inp_dis bit-position constants, shared with the register file and the chain cells.
- One sub-module, gpio_cfg_phase_timer: a loadable down-counter producing a terminal-count tick. It is reused for the CLK_DIV and LOAD_CYCLES phases.

Test Plan:
- Golden transfer: NUM_PADS=2, CFG_BITS=4, CLK_DIV=1, LOAD_CYCLES=1; cfg[1]=4'hA, cfg[0]=4'h3; start at cycle 0. Expect:
  - serial_data_out sampled on serial_clock rises = 1,0,1,0,0,0,1,1;
  - serial_load high in cycle 19;
  - done in cycle 20;
  - chain model shows pad1=A, pad0=3.
- CLK_DIV=3: every serial_clock high and low phase lasts exactly 3 cycles, and data never changes while serial_clock=1.
- Start asserted during busy (cycle 5) and again in the DONE cycle -> no restart, exactly one done pulse, identical bit stream.
- wb_rst_i asserted mid-SHIFT_HI of pad 1 -> next cycle serial_clock=0, busy=0, serial_load never asserted. A fresh start then produces the full golden stream.
- cfg_rdata changed to 4'hF during pad 1 shifting (after its FETCH) -> pad 1 still receives 4'hA.
- Default parameters (38 pads, 13 bits, CLK_DIV=2) with random cfg -> 494 rising edges of serial_clock, done at cycle 1+38*53+2=2017, and the chain model matches the register file.

Source files
------------

// File: rtl/gpio_cfg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gpio_cfg_pkg
// Description : Shared definitions for the GPIO configuration serial chain:
//               loader FSM state encoding, default word width and the bit
//               positions of the per-pad configuration fields.
// Revision    : 1.0 - initial release
// ============================================================================
package gpio_cfg_pkg;

    // Default number of configuration bits carried per pad
    localparam int c_cfg_bits_default = 13;

    // Per-pad configuration word layout (shared with the register file and
    // the chain cells beside the pads)
    localparam int c_cfg_mgmt_ena_bit  = 0;
    localparam int c_cfg_oeb_bit       = 1;
    localparam int c_cfg_holdover_bit  = 2;
    localparam int c_cfg_inp_dis_bit   = 3;
    localparam int c_cfg_ib_mode_bit   = 4;
    localparam int c_cfg_anlg_en_bit   = 5;
    localparam int c_cfg_anlg_sel_bit  = 6;
    localparam int c_cfg_anlg_pol_bit  = 7;
    localparam int c_cfg_slow_bit      = 8;
    localparam int c_cfg_vtrip_bit     = 9;
    localparam int c_cfg_dm_lsb        = 10;
    localparam int c_cfg_dm_msb        = 12;

    // Loader FSM state encoding
    typedef logic [2:0] state_t;
    localparam state_t c_st_idle     = 3'd0;
    localparam state_t c_st_fetch    = 3'd1;
    localparam state_t c_st_shift_lo = 3'd2;
    localparam state_t c_st_shift_hi = 3'd3;
    localparam state_t c_st_load     = 3'd4;
    localparam state_t c_st_done     = 3'd5;

    // Larger of two integers, used when sizing shared counters
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gpio_cfg_phase_timer.sv
`default_nettype none
// ============================================================================
// Module      : gpio_cfg_phase_timer
// Description : Loadable down-counter. o_tick is high while the count is zero,
//               so a phase loaded with N-1 lasts exactly N cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module gpio_cfg_phase_timer #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_value,
    output logic             o_tick
);

    logic [WIDTH-1:0] r_count;

    // Reload on request, otherwise count down and park at zero
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (r_count != '0) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_tick = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/gpio_cfg_serial_loader.sv
`default_nettype none
// ============================================================================
// Module      : gpio_cfg_serial_loader
// Description : Walks the pad configuration register file from the highest
//               pad down to pad 0, shifting each word MSB first onto the
//               GPIO daisy chain, then strobes serial_load so every pad
//               latches its new configuration.
// Revision    : 1.0 - initial release
// ============================================================================
module gpio_cfg_serial_loader
    import gpio_cfg_pkg::*;
#(
    parameter int NUM_PADS    = 38,
    parameter int CFG_BITS    = c_cfg_bits_default,
    parameter int CLK_DIV     = 2,
    parameter int LOAD_CYCLES = 2
) (
    input  logic                        wb_clk_i,
    input  logic                        wb_rst_i,
    input  logic                        start,
    output logic [$clog2(NUM_PADS)-1:0] cfg_addr,
    input  logic [CFG_BITS-1:0]         cfg_rdata,
    output logic                        serial_clock,
    output logic                        serial_data_out,
    output logic                        serial_load,
    output logic                        busy,
    output logic                        done
);

    localparam int c_addr_w = $clog2(NUM_PADS);
    localparam int c_bit_w  = $clog2(CFG_BITS);
    localparam int c_div_w  = $clog2(max_int(CLK_DIV, LOAD_CYCLES)) + 1;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [c_addr_w-1:0]   r_pad_cnt;
    logic [c_bit_w-1:0]    r_bit_cnt;
    logic [CFG_BITS-1:0]   r_shift;
    logic [CFG_BITS-1:0]   w_shift_nxt;

    logic                  r_serial_clock;
    logic                  r_serial_data;
    logic                  r_serial_load;
    logic                  r_busy;
    logic                  r_done;

    logic                  w_tick;
    logic                  w_timer_load;
    logic [c_div_w-1:0]    w_timer_value;

    // Every state change starts a new timed phase; only LOAD uses its own length
    assign w_timer_load  = (w_state_nxt != r_state);
    assign w_timer_value = (w_state_nxt == c_st_load) ? c_div_w'(LOAD_CYCLES - 1)
                                                      : c_div_w'(CLK_DIV - 1);

    gpio_cfg_phase_timer #(
        .WIDTH   (c_div_w)
    ) u_phase_timer (
        .clk     (wb_clk_i),
        .rst     (wb_rst_i),
        .i_load  (w_timer_load),
        .i_value (w_timer_value),
        .o_tick  (w_tick)
    );

    // Next-state decode: phase lengths come from the timer tick
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle:     if (start) w_state_nxt = c_st_fetch;
            c_st_fetch:    w_state_nxt = c_st_shift_lo;
            c_st_shift_lo: if (w_tick) w_state_nxt = c_st_shift_hi;
            c_st_shift_hi: begin
                if (w_tick) begin
                    if (r_bit_cnt != '0) begin
                        w_state_nxt = c_st_shift_lo;
                    end else if (r_pad_cnt != '0) begin
                        w_state_nxt = c_st_fetch;
                    end else begin
                        w_state_nxt = c_st_load;
                    end
                end
            end
            c_st_load:     if (w_tick) w_state_nxt = c_st_done;
            c_st_done:     w_state_nxt = c_st_idle;
            default:       w_state_nxt = c_st_idle;
        endcase
    end

    // Shift register: capture the word in FETCH, advance after each high phase
    always_comb begin
        w_shift_nxt = r_shift;
        if (r_state == c_st_fetch) begin
            w_shift_nxt = cfg_rdata;
        end else if ((r_state == c_st_shift_hi) && w_tick && (r_bit_cnt != '0)) begin
            w_shift_nxt = r_shift << 1;
        end
    end

    // State, pad counter and bit counter
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state   <= c_st_idle;
            r_pad_cnt <= c_addr_w'(NUM_PADS - 1);
            r_bit_cnt <= '0;
            r_shift   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_shift <= w_shift_nxt;
            if ((r_state == c_st_idle) && start) begin
                r_pad_cnt <= c_addr_w'(NUM_PADS - 1);
            end
            if (r_state == c_st_fetch) begin
                r_bit_cnt <= c_bit_w'(CFG_BITS - 1);
            end
            if ((r_state == c_st_shift_hi) && w_tick) begin
                if (r_bit_cnt != '0) begin
                    r_bit_cnt <= r_bit_cnt - c_bit_w'(1);
                end else if (r_pad_cnt != '0) begin
                    r_pad_cnt <= r_pad_cnt - c_addr_w'(1);
                end
            end
        end
    end

    // Outputs registered from the next state so the chain sees clean edges
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_serial_clock <= 1'b0;
            r_serial_data  <= 1'b0;
            r_serial_load  <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            r_serial_clock <= (w_state_nxt == c_st_shift_hi);
            r_serial_data  <= ((w_state_nxt == c_st_shift_lo) || (w_state_nxt == c_st_shift_hi))
                              ? w_shift_nxt[CFG_BITS-1] : 1'b0;
            r_serial_load  <= (w_state_nxt == c_st_load);
            r_busy         <= (w_state_nxt == c_st_fetch)    || (w_state_nxt == c_st_shift_lo) ||
                              (w_state_nxt == c_st_shift_hi) || (w_state_nxt == c_st_load);
            r_done         <= (w_state_nxt == c_st_done);
        end
    end

    assign cfg_addr        = r_pad_cnt;
    assign serial_clock    = r_serial_clock;
    assign serial_data_out = r_serial_data;
    assign serial_load     = r_serial_load;
    assign busy            = r_busy;
    assign done            = r_done;

endmodule
`default_nettype wire

// File: tb/tb_gpio_cfg_serial_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_gpio_cfg_serial_loader
// Description : Bench for the GPIO configuration loader. Three instances:
//               golden (2 pads x 4 bits, div 1), slow clock (div 3) and the
//               default 38 x 13 configuration. Expected waveforms come from a
//               cycle-position model of the transfer; a chain model shifts on
//               serial_clock rises and latches on serial_load.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gpio_cfg_serial_loader;

    localparam int c_sent = -1000000;

    typedef struct packed {
        logic sclk;
        logic load;
        logic busy;
        logic done;
        logic dvalid;
        logic fetch;
        int   pad;
        int   bitn;
    } exp_t;

    logic clk = 1'b0;
    initial forever #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;
    logic chk_en = 1'b0;

    // ---------------- golden instance ----------------
    logic       rst_g, start_g, sclk_g, sdo_g, load_g, busy_g, done_g, override_g;
    logic [0:0] addr_g;
    logic [3:0] rdata_g;
    logic [3:0] cfg_g [2];
    int         t0_g = c_sent;
    int         scen_g = 0;
    assign rdata_g = override_g ? 4'hF : cfg_g[addr_g];

    gpio_cfg_serial_loader #(.NUM_PADS(2), .CFG_BITS(4), .CLK_DIV(1), .LOAD_CYCLES(1)) u_dut_g (
        .wb_clk_i(clk), .wb_rst_i(rst_g), .start(start_g), .cfg_addr(addr_g), .cfg_rdata(rdata_g),
        .serial_clock(sclk_g), .serial_data_out(sdo_g), .serial_load(load_g), .busy(busy_g), .done(done_g));

    // ---------------- CLK_DIV=3 instance ----------------
    logic       rst_d, start_d, sclk_d, sdo_d, load_d, busy_d, done_d;
    logic [0:0] addr_d;
    logic [3:0] rdata_d;
    logic [3:0] cfg_d [2];
    int         t0_d = c_sent;
    assign rdata_d = cfg_d[addr_d];

    gpio_cfg_serial_loader #(.NUM_PADS(2), .CFG_BITS(4), .CLK_DIV(3), .LOAD_CYCLES(1)) u_dut_d (
        .wb_clk_i(clk), .wb_rst_i(rst_d), .start(start_d), .cfg_addr(addr_d), .cfg_rdata(rdata_d),
        .serial_clock(sclk_d), .serial_data_out(sdo_d), .serial_load(load_d), .busy(busy_d), .done(done_d));

    // ---------------- default instance ----------------
    logic        rst_b, start_b, sclk_b, sdo_b, load_b, busy_b, done_b;
    logic [5:0]  addr_b;
    logic [12:0] rdata_b;
    logic [12:0] cfg_b [64];
    int          t0_b = c_sent;
    assign rdata_b = cfg_b[addr_b];

    gpio_cfg_serial_loader u_dut_b (
        .wb_clk_i(clk), .wb_rst_i(rst_b), .start(start_b), .cfg_addr(addr_b), .cfg_rdata(rdata_b),
        .serial_clock(sclk_b), .serial_data_out(sdo_b), .serial_load(load_b), .busy(busy_b), .done(done_b));

    // Where a transfer started at t=0 must be at cycle t, from the stated
    // timing: per pad one fetch cycle then b bits of (d low + d high) cycles,
    // then lc load cycles, then one done cycle.
    function automatic exp_t model(input int t, input int n, input int b, input int d, input int lc);
        exp_t e;
        int plen, p, r, q;
        e = '0;
        plen = 1 + 2 * d * b;
        if (t < 1 || t > 1 + n * plen + lc) return e;
        if (t == 1 + n * plen + lc) begin
            e.done = 1'b1;
            return e;
        end
        e.busy = 1'b1;
        if (t > n * plen) begin
            e.load = 1'b1;
            return e;
        end
        p = t - 1;
        e.pad = n - 1 - p / plen;
        r = p % plen;
        if (r == 0) begin
            e.fetch = 1'b1;
        end else begin
            q = r - 1;
            e.dvalid = 1'b1;
            e.bitn = b - 1 - q / (2 * d);
            e.sclk = ((q % (2 * d)) >= d);
        end
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s cycle=%0d actual=%0h required=%0h", nm, cyc, act, req);
        end
    endtask

    // Per-transfer observations
    logic [7:0]   chain_g, stream_g, chain_d, stream_d;
    logic [493:0] chain_b;
    logic [3:0]   lat_g [2];
    logic [3:0]   lat_d [2];
    logic [12:0]  lat_b [38];
    logic psclk_g = 0, pload_g = 0, psclk_d = 0, pload_d = 0, psdo_d = 0, psclk_b = 0, pload_b = 0;
    int rises_g, load_t_g, done_t_g, done_cnt_g, load_total_g = 0;
    int rises_d, load_t_d, done_t_d, hirun_d, hiruns_d, hibad_d, chg_d;
    int rises_b, load_t_b, done_t_b, mism_b;
    int t;
    exp_t e;

    // Compare process: every cycle, away from the active edge
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            // ----- golden -----
            t = cyc - t0_g;
            e = model(t, 2, 4, 1, 1);
            chk("g_sclk", 32'(sclk_g), 32'(e.sclk));
            chk("g_load", 32'(load_g), 32'(e.load));
            chk("g_busy", 32'(busy_g), 32'(e.busy));
            chk("g_done", 32'(done_g), 32'(e.done));
            if (e.dvalid) chk("g_sdo", 32'(sdo_g), 32'(cfg_g[e.pad][e.bitn]));
            if (e.fetch)  chk("g_addr", 32'(addr_g), 32'(e.pad));
            if (t0_g == c_sent) begin
                chk("g_rst_addr", 32'(addr_g), 32'd1);
                chk("g_rst_sdo", 32'(sdo_g), 32'd0);
            end
            if (t == 0) begin
                stream_g = '0; rises_g = 0; load_t_g = -1; done_t_g = -1; done_cnt_g = 0;
            end
            if (sclk_g && !psclk_g) begin
                chain_g  = {chain_g[6:0], sdo_g};
                stream_g = {stream_g[6:0], sdo_g};
                rises_g++;
            end
            if (load_g) begin
                lat_g[0] = chain_g[3:0];
                lat_g[1] = chain_g[7:4];
            end
            if (load_g && !pload_g) begin
                load_total_g++;
                if (load_t_g < 0) load_t_g = t;
            end
            if (done_g) begin
                done_cnt_g++;
                if (done_t_g < 0) done_t_g = t;
            end
            psclk_g = sclk_g;
            pload_g = load_g;
            if (t == 20) begin
                chk("g_stream", 32'(stream_g), 32'hA3);
                chk("g_load_cycle", load_t_g, 19);
                chk("g_done_cycle", done_t_g, 20);
                chk("g_done_count", done_cnt_g, 1);
                chk("g_pad1", 32'(lat_g[1]), 32'hA);
                chk("g_pad0", 32'(lat_g[0]), 32'h3);
                if (scen_g == 4) chk("g_loads_after_abort", load_total_g, 3);
                if (scen_g == 5) chk("g_loads_total", load_total_g, 4);
            end

            // ----- CLK_DIV=3 -----
            t = cyc - t0_d;
            e = model(t, 2, 4, 3, 1);
            chk("d_sclk", 32'(sclk_d), 32'(e.sclk));
            chk("d_load", 32'(load_d), 32'(e.load));
            chk("d_busy", 32'(busy_d), 32'(e.busy));
            chk("d_done", 32'(done_d), 32'(e.done));
            if (e.dvalid) chk("d_sdo", 32'(sdo_d), 32'(cfg_d[e.pad][e.bitn]));
            if (e.fetch)  chk("d_addr", 32'(addr_d), 32'(e.pad));
            if (t0_d == c_sent) begin
                chk("d_rst_addr", 32'(addr_d), 32'd1);
                chk("d_rst_sdo", 32'(sdo_d), 32'd0);
            end
            if (t == 0) begin
                stream_d = '0; rises_d = 0; load_t_d = -1; done_t_d = -1;
                hirun_d = 0; hiruns_d = 0; hibad_d = 0; chg_d = 0;
            end
            if (sclk_d && !psclk_d) begin
                chain_d  = {chain_d[6:0], sdo_d};
                stream_d = {stream_d[6:0], sdo_d};
                rises_d++;
            end
            if (sclk_d) begin
                hirun_d++;
                if (psclk_d && (sdo_d != psdo_d)) chg_d++;
            end else if (psclk_d) begin
                hiruns_d++;
                if (hirun_d != 3) hibad_d++;
                hirun_d = 0;
            end
            if (load_d) begin
                lat_d[0] = chain_d[3:0];
                lat_d[1] = chain_d[7:4];
            end
            if (load_d && !pload_d && load_t_d < 0) load_t_d = t;
            if (done_d && done_t_d < 0) done_t_d = t;
            psclk_d = sclk_d;
            pload_d = load_d;
            psdo_d  = sdo_d;
            if (t == 52) begin
                chk("d_stream", 32'(stream_d), 32'h69);
                chk("d_rises", rises_d, 8);
                chk("d_high_phases", hiruns_d, 8);
                chk("d_bad_high_len", hibad_d, 0);
                chk("d_data_chg_high", chg_d, 0);
                chk("d_load_cycle", load_t_d, 51);
                chk("d_done_cycle", done_t_d, 52);
                chk("d_pad1", 32'(lat_d[1]), 32'h6);
                chk("d_pad0", 32'(lat_d[0]), 32'h9);
            end

            // ----- default 38 x 13 -----
            t = cyc - t0_b;
            e = model(t, 38, 13, 2, 2);
            chk("b_sclk", 32'(sclk_b), 32'(e.sclk));
            chk("b_load", 32'(load_b), 32'(e.load));
            chk("b_busy", 32'(busy_b), 32'(e.busy));
            chk("b_done", 32'(done_b), 32'(e.done));
            if (e.dvalid) chk("b_sdo", 32'(sdo_b), 32'(cfg_b[e.pad][e.bitn]));
            if (e.fetch)  chk("b_addr", 32'(addr_b), 32'(e.pad));
            if (t0_b == c_sent) begin
                chk("b_rst_addr", 32'(addr_b), 32'd37);
                chk("b_rst_sdo", 32'(sdo_b), 32'd0);
            end
            if (t == 0) begin
                rises_b = 0; load_t_b = -1; done_t_b = -1;
            end
            if (sclk_b && !psclk_b) begin
                chain_b = {chain_b[492:0], sdo_b};
                rises_b++;
            end
            if (load_b) begin
                for (int k = 0; k < 38; k++) lat_b[k] = chain_b[k*13 +: 13];
            end
            if (load_b && !pload_b && load_t_b < 0) load_t_b = t;
            if (done_b && done_t_b < 0) done_t_b = t;
            psclk_b = sclk_b;
            pload_b = load_b;
            if (t == 2017) begin
                mism_b = 0;
                for (int k = 0; k < 38; k++) if (lat_b[k] !== cfg_b[k]) mism_b++;
                chk("b_rises", rises_b, 494);
                chk("b_load_cycle", load_t_b, 2015);
                chk("b_done_cycle", done_t_b, 2017);
                chk("b_chain_mismatches", mism_b, 0);
                chk("b_pad37", 32'(lat_b[37]), 32'(cfg_b[37]));
            end
        end
    end

    // Advance n cycles and land just after the active edge
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Stimulus
    initial begin
        rst_g = 1'b1; rst_d = 1'b1; rst_b = 1'b1;
        start_g = 1'b0; start_d = 1'b0; start_b = 1'b0;
        override_g = 1'b0;
        cfg_g[0] = 4'h3; cfg_g[1] = 4'hA;
        cfg_d[0] = 4'h9; cfg_d[1] = 4'h6;
        for (int k = 0; k < 64; k++) cfg_b[k] = (k < 38) ? 13'($urandom) : 13'h0;
        chain_g = '0; chain_d = '0; chain_b = '0;
        tick(3);
        rst_g = 1'b0; rst_d = 1'b0; rst_b = 1'b0;
        chk_en = 1'b1;
        tick(3);

        // Golden transfer
        scen_g = 1; start_g = 1'b1; t0_g = cyc;
        tick(1); start_g = 1'b0;
        tick(25);

        // Start while busy (t=5) and in the DONE cycle (t=20)
        scen_g = 2; start_g = 1'b1; t0_g = cyc;
        tick(1); start_g = 1'b0;
        tick(4); start_g = 1'b1;
        tick(1); start_g = 1'b0;
        tick(14); start_g = 1'b1;
        tick(1); start_g = 1'b0;
        tick(5);

        // Reset during the first high phase of pad 1 (t=3)
        scen_g = 3; start_g = 1'b1; t0_g = cyc;
        tick(1); start_g = 1'b0;
        tick(2); rst_g = 1'b1;
        tick(1); rst_g = 1'b0; t0_g = c_sent;
        tick(6);

        // Fresh transfer after the abort
        scen_g = 4; start_g = 1'b1; t0_g = cyc;
        tick(1); start_g = 1'b0;
        tick(25);

        // Register file changes under pad 1 after its fetch
        scen_g = 5; start_g = 1'b1; t0_g = cyc;
        tick(1); start_g = 1'b0;
        tick(1); override_g = 1'b1;
        tick(6); override_g = 1'b0;
        tick(18);

        // Slow serial clock
        start_d = 1'b1; t0_d = cyc;
        tick(1); start_d = 1'b0;
        tick(56);

        // Default-size chain
        start_b = 1'b1; t0_b = cyc;
        tick(1); start_b = 1'b0;
        tick(2022);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
